mem_dbus_ctrl: RTL and testbench

MEM_DBUS_CTRL -- requirements
Module: mem_dbus_ctrl

---
 rtl/mem_dbus_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_dbus_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dbus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_dbus_ctrl
//
// Bridges the M stage of an in-order pipeline onto a single-outstanding,
// valid/ready data bus. A naturally aligned load or store found in the M
// stage is latched into request registers, offered on the bus until it is
// accepted, and then the controller waits for the response (read data or
// write acknowledge). The pipeline is frozen with stallM from the cycle the
// access is seen until the response (or a timeout) arrives. Misaligned
// accesses never reach the bus; they are reported immediately on memerrM.
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent waiting for a response before giving up
//                   and flagging an error (1..65535)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   MemReadM     M-stage instruction is a load
//   MemWriteM    M-stage instruction is a store (wins over MemReadM)
//   aluoutM      M-stage effective byte address
//   writedataM   M-stage store data
//   dreq_valid   request valid (held until dreq_ready)
//   dreq_write   request is a write (1) or a read (0)
//   dreq_addr    request word address, bits [1:0] always zero
//   dreq_wdata   store data
//   dreq_ready   bus accepts the request this cycle
//   drsp_valid   response valid (read data or write acknowledge)
//   drsp_rdata   read response data
//   drsp_err     bus error, qualified by drsp_valid
//   stallM       freezes pipeline stages F through M
//   readdataM    registered result of the last successful load
//   memerrM      one-cycle error pulse: misaligned, bus error or timeout
// ---------------------------------------------------------------------------
module mem_dbus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic        dreq_valid,
  output logic        dreq_write,
  output logic [31:0] dreq_addr,
  output logic [31:0] dreq_wdata,
  input  logic        dreq_ready,
  input  logic        drsp_valid,
  input  logic [31:0] drsp_rdata,
  input  logic        drsp_err,
  output logic        stallM,
  output logic [31:0] readdataM,
  output logic        memerrM
);

  // Counter is just wide enough to hold TIMEOUT_CYCLES; it stops at
  // TIMEOUT_CYCLES-1, so it can never wrap.
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             err;

  logic access;
  logic mis;
  logic start;

  assign access = MemReadM | MemWriteM;
  assign mis    = access & (aluoutM[1:0] != 2'b00);
  assign start  = access & ~mis;

  // -------------------------------------------------------------------------
  // Control state and request/response registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      err        <= 1'b0;
      dreq_write <= 1'b0;
      dreq_addr  <= 32'h0;
      dreq_wdata <= 32'h0;
      readdataM  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          // M-stage inputs are only sampled here; afterwards the latched
          // copies drive the bus so the pipeline may present anything.
          if (start) begin
            state      <= S_REQ;
            dreq_write <= MemWriteM;
            dreq_addr  <= {aluoutM[31:2], 2'b00};
            dreq_wdata <= writedataM;
          end
        end

        S_REQ: begin
          if (dreq_ready) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end

        S_WAIT: begin
          // A response arriving on the timeout cycle still wins.
          if (drsp_valid) begin
            state <= S_DONE;
            err   <= drsp_err;
            if (!dreq_write && !drsp_err) begin
              readdataM <= drsp_rdata;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state <= S_DONE;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from state
  // -------------------------------------------------------------------------
  assign dreq_valid = (state == S_REQ);

  // In IDLE the stall and error are combinational so the pipeline freezes
  // in the very cycle the access appears; responses seen outside WAIT are
  // stale and never influence any output.
  always_comb begin
    stallM  = 1'b0;
    memerrM = 1'b0;
    case (state)
      S_IDLE: begin
        stallM  = start;
        memerrM = mis;
      end
      S_REQ:   stallM  = 1'b1;
      S_WAIT:  stallM  = 1'b1;
      S_DONE:  memerrM = err;
      default: begin
        stallM  = 1'b0;
        memerrM = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_dbus_ctrl
//
// Scoreboard bench for mem_dbus_ctrl. A driver issues M-stage accesses and
// plays the bus side with chosen acceptance/response delays; for each access
// it predicts, from the behavioural rules, the bus request the controller
// must present and the completion it must report (error flag, load result,
// number of stalled cycles). Two monitors independently watch the request
// bus and the completion outputs and compare against the queued predictions.
// ---------------------------------------------------------------------------
module tb_mem_dbus_ctrl;

  localparam int T = 4;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        dreq_valid;
  logic        dreq_write;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wdata;
  logic        dreq_ready;
  logic        drsp_valid;
  logic [31:0] drsp_rdata;
  logic        drsp_err;
  logic        stallM;
  logic [31:0] readdataM;
  logic        memerrM;

  mem_dbus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .dreq_valid (dreq_valid),
    .dreq_write (dreq_write),
    .dreq_addr  (dreq_addr),
    .dreq_wdata (dreq_wdata),
    .dreq_ready (dreq_ready),
    .drsp_valid (drsp_valid),
    .drsp_rdata (drsp_rdata),
    .drsp_err   (drsp_err),
    .stallM     (stallM),
    .readdataM  (readdataM),
    .memerrM    (memerrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nvld;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          nstall;
  } cmp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];

  int          total;
  int          passed;
  logic        mon_en;
  logic [31:0] model_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_m();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    aluoutM    = 32'h0;
    writedataM = 32'h0;
  endtask

  // One access, started at a negedge with the controller idle; returns at a
  // negedge with the controller idle again. rsp_dly counts WAIT cycles before
  // the response; rsp_dly >= T means the response comes too late.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                        input logic rsp_err, input logic [31:0] rdata, input logic garbage);
    req_t r;
    cmp_t c;
    int   wcyc;
    MemReadM   = rd;
    MemWriteM  = wr;
    aluoutM    = addr;
    writedataM = wdata;
    if (!(rd || wr)) begin
      @(negedge clk);
      return;
    end
    if (addr[1:0] != 2'b00) begin
      c.err = 1'b1; c.rd = model_rd; c.nstall = 0;
      cmp_q.push_back(c);
      @(negedge clk);
      clear_m();
      return;
    end
    r.wr = wr; r.addr = {addr[31:2], 2'b00}; r.wdata = wdata; r.nvld = rdy_dly + 1;
    req_q.push_back(r);
    if (rsp_dly < T) begin
      c.err = rsp_err;
      if (!wr && !rsp_err) model_rd = rdata;
      wcyc = rsp_dly + 1;
    end else begin
      c.err = 1'b1;
      wcyc = T;
    end
    c.rd = model_rd;
    c.nstall = 2 + rdy_dly + wcyc;
    cmp_q.push_back(c);

    @(negedge clk);
    if (garbage) begin
      MemReadM   = 1'($urandom);
      MemWriteM  = 1'($urandom);
      aluoutM    = $urandom;
      writedataM = $urandom;
    end
    for (int i = 0; i < rdy_dly; i++) begin
      dreq_ready = 1'b0;
      drsp_valid = 1'($urandom);
      drsp_rdata = $urandom;
      drsp_err   = 1'($urandom);
      @(negedge clk);
    end
    dreq_ready = 1'b1;
    drsp_valid = 1'b0;
    drsp_err   = 1'b0;
    @(negedge clk);
    dreq_ready = 1'b0;
    clear_m();
    for (int k = 0; k < rsp_dly; k++) @(negedge clk);
    drsp_valid = 1'b1;
    drsp_rdata = rdata;
    drsp_err   = rsp_err;
    @(negedge clk);
    drsp_valid = 1'b0;
    drsp_err   = 1'b0;
    @(negedge clk);
  endtask

  // Request-bus monitor
  initial begin : req_mon
    int   vcnt;
    req_t e;
    vcnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        vcnt = 0;
      end else if (dreq_valid) begin
        total++;
        if (req_q.size() == 0) begin
          $display("FAIL unexpected_request: dreq_valid=1 with no request outstanding, addr=0x%0h", dreq_addr);
        end else begin
          passed++;
          e = req_q[0];
          check("dreq_write", 32'(dreq_write), 32'(e.wr));
          check("dreq_addr", dreq_addr, e.addr);
          check("dreq_wdata", dreq_wdata, e.wdata);
          vcnt++;
          if (dreq_ready) begin
            check("dreq_valid_cycles", 32'(vcnt), 32'(e.nvld));
            void'(req_q.pop_front());
            vcnt = 0;
          end
        end
      end
    end
  end

  // Completion monitor
  initial begin : cmp_mon
    logic prev_stall;
    int   run;
    cmp_t e;
    prev_stall = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        prev_stall = 1'b0;
        run = 0;
      end else begin
        if (stallM) run++;
        if (!stallM && (prev_stall || memerrM)) begin
          total++;
          if (cmp_q.size() == 0) begin
            $display("FAIL unexpected_completion: memerrM=%0b readdataM=0x%0h with nothing pending", memerrM, readdataM);
          end else begin
            passed++;
            e = cmp_q.pop_front();
            check("memerrM", 32'(memerrM), 32'(e.err));
            check("readdataM", readdataM, e.rd);
            check("stall_cycles", 32'(run), 32'(e.nstall));
          end
          run = 0;
        end
        prev_stall = stallM;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        rd;
    logic        wr;
    logic [31:0] a;
    int          op;
    total = 0;
    passed = 0;
    mon_en = 1'b0;
    model_rd = 32'h0;
    reset = 1'b0;
    clear_m();
    dreq_ready = 1'b0;
    drsp_valid = 1'b0;
    drsp_rdata = 32'h0;
    drsp_err   = 1'b0;

    // Reset values, and the IDLE stall/error rule while held in reset
    repeat (2) @(negedge clk);
    #1;
    check("rst_dreq_valid", 32'(dreq_valid), 32'h0);
    check("rst_dreq_write", 32'(dreq_write), 32'h0);
    check("rst_dreq_addr", dreq_addr, 32'h0);
    check("rst_dreq_wdata", dreq_wdata, 32'h0);
    check("rst_readdataM", readdataM, 32'h0);
    check("rst_stallM", 32'(stallM), 32'h0);
    check("rst_memerrM", 32'(memerrM), 32'h0);
    MemReadM = 1'b1; aluoutM = 32'h100;
    #1;
    check("rst_stall_aligned", 32'(stallM), 32'h1);
    check("rst_memerr_aligned", 32'(memerrM), 32'h0);
    aluoutM = 32'h101;
    #1;
    check("rst_stall_misaligned", 32'(stallM), 32'h0);
    check("rst_memerr_misaligned", 32'(memerrM), 32'h1);
    clear_m();
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Directed: load, delayed-ready store, misaligned, bus error, timeout,
    // response on the timeout cycle, load+store together
    do_txn(1'b1, 1'b0, 32'h100, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    do_txn(1'b0, 1'b1, 32'h204, 32'h12345678, 3, 1, 1'b0, 32'h55AA55AA, 1'b0);
    do_txn(1'b1, 1'b0, 32'h102, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0);
    do_txn(1'b1, 1'b0, 32'h300, 32'h0, 1, 2, 1'b1, 32'h0BAD0BAD, 1'b0);
    do_txn(1'b1, 1'b0, 32'h400, 32'h0, 0, T, 1'b0, 32'h44444444, 1'b0);
    do_txn(1'b1, 1'b0, 32'h404, 32'h0, 0, T - 1, 1'b0, 32'h13579BDF, 1'b0);
    do_txn(1'b1, 1'b1, 32'h500, 32'hA5A5A5A5, 0, 0, 1'b0, 32'h77777777, 1'b0);

    // Randomised traffic with stale responses sprinkled between accesses
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 9);
      rd = (op >= 1 && op <= 4) || op == 8 || op == 9;
      wr = (op >= 5 && op <= 8);
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      else a[1:0] = 2'($urandom_range(1, 3));
      do_txn(rd, wr, a, $urandom, $urandom_range(0, 3), $urandom_range(0, T),
             ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        drsp_valid = 1'b1;
        drsp_rdata = $urandom;
        drsp_err   = 1'($urandom);
        @(negedge clk);
        drsp_valid = 1'b0;
        drsp_err   = 1'b0;
      end
    end

    // Reset in WAIT, then a stale response after release with no access
    do_txn(1'b1, 1'b0, 32'h800, 32'h0, 0, 0, 1'b0, 32'hFEEDFACE, 1'b0);
    mon_en = 1'b0;
    MemReadM = 1'b1; aluoutM = 32'h600;
    @(negedge clk);
    clear_m();
    dreq_ready = 1'b1;
    @(negedge clk);
    dreq_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_dreq_valid", 32'(dreq_valid), 32'h0);
    check("midrst_stallM", 32'(stallM), 32'h0);
    check("midrst_readdataM", readdataM, 32'h0);
    check("midrst_dreq_addr", dreq_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drsp_valid = 1'b1;
    drsp_rdata = 32'hCAFEF00D;
    drsp_err   = 1'b0;
    @(negedge clk);
    drsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stale_dreq_valid", 32'(dreq_valid), 32'h0);
      check("stale_stallM", 32'(stallM), 32'h0);
      check("stale_memerrM", 32'(memerrM), 32'h0);
      check("stale_readdataM", readdataM, 32'h0);
      @(negedge clk);
    end
    model_rd = 32'h0;
    mon_en = 1'b1;

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      a[1:0] = 2'b00;
      do_txn(1'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3),
             $urandom_range(0, T), ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("req_queue_drained", 32'(req_q.size()), 32'h0);
    check("cmp_queue_drained", 32'(cmp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
